// File: rtl/prog_mem_fetch.sv
// Loadable instruction memory: self-clears to NOP_WORD after reset, then serves valid/ready fetches via a 2-entry queue.
// Optional macro PROG_MEM_PARITY_EN adds one even-parity bit per word and a parity_err response output.
module prog_mem_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 27,
  parameter int unsigned       DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic              init_done,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_oor,
`ifdef PROG_MEM_PARITY_EN
  output logic              parity_err,
`endif
  input  logic              resp_ready
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
  localparam int unsigned ENT_W = DATA_W + ADDR_W + 2;
`else
  localparam int unsigned MEM_W = DATA_W;
  localparam int unsigned ENT_W = DATA_W + ADDR_W + 1;
`endif
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  clr_ptr, clr_ptr_next;
  logic              init_done_next, ld_err_next;
  logic              ld_in_range, req_in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_word;
  logic [ENT_W-1:0]  new_ent;
  logic [ENT_W-1:0]  q_ent [2];
  logic [1:0]        q_vld;
  logic              push, pop;

  // Stored word image: data plus, when enabled, an even-parity bit on top
  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef PROG_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign ld_in_range  = {1'b0, ld_addr}  < DEPTH_X;
  assign req_in_range = {1'b0, req_addr} < DEPTH_X;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLEAR;
      clr_ptr   <= '0;
      init_done <= 1'b0;
      ld_err    <= 1'b0;
    end else begin
      state     <= state_next;
      clr_ptr   <= clr_ptr_next;
      init_done <= init_done_next;
      ld_err    <= ld_err_next;
    end
  end

  // Next state, memory write port and fetch acceptance; loads take priority over fetches
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    mem_we       = 1'b0;
    mem_waddr    = clr_ptr;
    mem_wdata    = encode(NOP_WORD);
    ld_err_next  = 1'b0;
    req_ready    = 1'b0;
    unique case (state)
      S_CLEAR: begin
        mem_we      = 1'b1;
        ld_err_next = ld_en;
        if (clr_ptr == IDX_W'(DEPTH - 1)) state_next = S_RUN;
        else                              clr_ptr_next = clr_ptr + 1'b1;
      end
      S_RUN: begin
        req_ready = ~ld_en & ~q_vld[1];
        if (ld_en) begin
          if (ld_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr[IDX_W-1:0];
            mem_wdata = encode(ld_data);
          end else begin
            ld_err_next = 1'b1;
          end
        end
      end
    endcase
    init_done_next = (state_next == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_word = mem[req_addr[IDX_W-1:0]];

  // Response entry captured at accept; out-of-range reads return NOP_WORD with no parity error
  always_comb begin
`ifdef PROG_MEM_PARITY_EN
    new_ent = {req_in_range & (^rd_word), ~req_in_range, req_addr,
               req_in_range ? rd_word[DATA_W-1:0] : NOP_WORD};
`else
    new_ent = {~req_in_range, req_addr,
               req_in_range ? rd_word[DATA_W-1:0] : NOP_WORD};
`endif
  end

  assign push = req_valid & req_ready;
  assign pop  = q_vld[0] & resp_ready;

  // Two-entry in-order queue; slot 0 is the head and only changes on pop or when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ent[0] <= '0;
      q_ent[1] <= '0;
      q_vld    <= 2'b00;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (!q_vld[0]) begin
            q_ent[0] <= new_ent;
            q_vld[0] <= 1'b1;
          end else begin
            q_ent[1] <= new_ent;
            q_vld[1] <= 1'b1;
          end
        end
        2'b01: begin
          if (q_vld[1]) q_ent[0] <= q_ent[1];
          q_vld <= {1'b0, q_vld[1]};
        end
        2'b11: begin
          if (q_vld[1]) begin
            q_ent[0] <= q_ent[1];
            q_ent[1] <= new_ent;
          end else begin
            q_ent[0] <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = q_vld[0];
`ifdef PROG_MEM_PARITY_EN
  assign {parity_err, resp_oor, resp_addr, resp_data} = q_ent[0];
`else
  assign {resp_oor, resp_addr, resp_data} = q_ent[0];
`endif

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Scoreboard bench for prog_mem_fetch: directed loads/fetches, expectations queued at accept, checked by a monitor.
module tb_prog_mem_fetch;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 27;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_err;
  logic              init_done;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_oor;
  logic              resp_ready;
`ifdef PROG_MEM_PARITY_EN
  logic              parity_err;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              oor;
    logic              perr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t held;
  logic hold_v = 1'b0;
  int   checks = 0;
  int   failures = 0;

  prog_mem_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_err     (ld_err),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .resp_oor   (resp_oor),
`ifdef PROG_MEM_PARITY_EN
    .parity_err (parity_err),
`endif
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on each transfer and checks that a stalled head stays put
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && resp_valid) begin
        chk("hold_data", resp_data, held.data);
        chk("hold_addr", resp_addr, held.addr);
        chk("hold_oor", resp_oor, held.oor);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got addr %0h expected no response", resp_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_addr", resp_addr, mon_e.addr);
          chk("resp_oor", resp_oor, mon_e.oor);
`ifdef PROG_MEM_PARITY_EN
          chk("parity_err", parity_err, mon_e.perr);
`endif
        end
      end
      hold_v    = resp_valid && !resp_ready;
      held.data = resp_data;
      held.addr = resp_addr;
      held.oor  = resp_oor;
      held.perr = 1'b0;
    end
  end

  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic oor, input logic perr);
    logic rdy;
    bit   ok = 0;
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (ok) begin
      e.data = d;
      e.addr = a;
      e.oor  = oor;
      e.perr = perr;
      exp_q.push_back(e);
    end else begin
      checks++;
      failures++;
      $display("FAIL fetch_accept: got no accept for addr %0h expected accept within 40 cycles", a);
    end
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic exp_err);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    chk("ld_err", ld_err, exp_err);
    if (exp_err) begin
      @(posedge clk);
      #1;
      chk("ld_err_pulse_end", ld_err, 0);
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_cycles", n, DEPTH);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !resp_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    #12;
    chk("rst_init_done", init_done, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_oor", resp_oor, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_addr", resp_addr, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    wait_init();

    // Cleared memory reads as zero
    resp_ready = 1'b1;
    fetch(16'd5, 27'h0, 1'b0, 1'b0);
    wait_drain();

    // Load then fetch in order, head visible one cycle after accept
    load(16'd0, 27'h4A_FFFF, 1'b0);
    load(16'd4, 27'h440_000F, 1'b0);
    fetch(16'd0, 27'h4A_FFFF, 1'b0, 1'b0);
    chk("fetch_latency", resp_valid, 1);
    fetch(16'd4, 27'h440_000F, 1'b0, 1'b0);
    wait_drain();

    // Backpressure: two queued, third stalls until the consumer resumes
    resp_ready = 1'b0;
    fetch(16'd0, 27'h4A_FFFF, 1'b0, 1'b0);
    fetch(16'd4, 27'h440_000F, 1'b0, 1'b0);
    chk("full_req_ready", req_ready, 0);
    chk("full_head_data", resp_data, 27'h4A_FFFF);
    fork
      begin
        repeat (4) @(posedge clk);
        #2 resp_ready = 1'b1;
      end
      fetch(16'd5, 27'h0, 1'b0, 1'b0);
    join
    wait_drain();

    // Out of range fetch and load
    fetch(16'd256, 27'h0, 1'b1, 1'b0);
    wait_drain();
    load(16'd300, 27'h123_4567, 1'b1);
    fetch(16'd44, 27'h0, 1'b0, 1'b0);
    wait_drain();

    // Load/fetch conflict: load wins, fetch next cycle sees the new word
    ld_en = 1'b1; ld_addr = 16'd9; ld_data = 27'h2AB_CDEF;
    req_valid = 1'b1; req_addr = 16'd9;
    @(negedge clk);
    chk("conflict_req_ready", req_ready, 0);
    @(posedge clk);
    #1 ld_en = 1'b0;
    chk("conflict_ld_err", ld_err, 0);
    fetch(16'd9, 27'h2AB_CDEF, 1'b0, 1'b0);
    wait_drain();

    // Reset with two responses queued
    resp_ready = 1'b0;
    fetch(16'd0, 27'h4A_FFFF, 1'b0, 1'b0);
    fetch(16'd4, 27'h440_000F, 1'b0, 1'b0);
    chk("pre_rst_valid", resp_valid, 1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_resp_data", resp_data, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    resp_ready = 1'b1;
    wait_init();
    fetch(16'd4, 27'h0, 1'b0, 1'b0);
    wait_drain();

`ifdef PROG_MEM_PARITY_EN
    // Corrupt one stored bit and confirm detection; clean word reports no error
    load(16'd4, 27'h440_000F, 1'b0);
    dut.mem[4][0] = ~dut.mem[4][0];
    fetch(16'd4, 27'h440_000E, 1'b0, 1'b1);
    fetch(16'd0, 27'h0, 1'b0, 1'b0);
    fetch(16'd256, 27'h0, 1'b1, 1'b0);
    wait_drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
